memory_dumper: RTL and testbench

- Transmit-side counterpart of the boot-time program loader.
- On a start pulse, reads a block of 32-bit words from data memory and streams it byte-wise into the UART transmit path.
- Stream format is the one the loader consumes: a 32-bit little-endian size word (byte count), followed by each data word, little-endian.
- Used for result dumps and memory readback to the host after a program has run.

---
 rtl/memory_dumper_if.sv | 20 ++
 rtl/memory_dumper.sv | 91 +++++++++
 tb/tb_memory_dumper.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_dumper_if.sv
// Memory-read and UART-transmit handshakes of the memory dumper.
// master = dumper side, slave = memory/transmitter side.
interface memory_dumper_if;
  logic        data_mem_out_valid;
  logic [31:0] data_mem_out_addr;
  logic        data_mem_out_ready;
  logic [31:0] data_mem_out_data;
  logic        uart_in_valid;
  logic [7:0]  uart_in_data;
  logic        uart_in_ready;

  modport master (
    output data_mem_out_valid, data_mem_out_addr, uart_in_valid, uart_in_data,
    input  data_mem_out_ready, data_mem_out_data, uart_in_ready
  );
  modport slave (
    input  data_mem_out_valid, data_mem_out_addr, uart_in_valid, uart_in_data,
    output data_mem_out_ready, data_mem_out_data, uart_in_ready
  );
endinterface

// File: rtl/memory_dumper.sv
// Streams a block of memory words byte-wise to the UART, optionally preceded
// by a little-endian byte-count header in the format the boot loader expects.
module memory_dumper #(
  parameter bit SEND_HEADER = 1'b1,
  parameter int ADDR_STEP   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            base_addr,
  input  logic [31:0]            word_count,
  output logic                   busy,
  output logic                   completed,
  memory_dumper_if.master        bus
);
  typedef enum logic [2:0] {IDLE, SEND_SIZE, FETCH, SEND_WORD, DONE} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] remaining_q;
  logic [31:0] buf_q;
  logic [1:0]  idx_q;
  logic        mvalid_q;
  logic        uvalid_q;

  assign busy                   = (state_q != IDLE) && (state_q != DONE);
  assign completed              = (state_q == DONE);
  assign bus.data_mem_out_valid = mvalid_q;
  assign bus.data_mem_out_addr  = addr_q;
  assign bus.uart_in_valid      = uvalid_q;
  assign bus.uart_in_data       = buf_q[{idx_q, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
      idx_q       <= '0;
      mvalid_q    <= 1'b0;
      uvalid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            addr_q      <= base_addr;
            remaining_q <= word_count;
            if (SEND_HEADER) begin
              // header counts bytes; wraps silently for word_count >= 2^30
              buf_q    <= word_count << 2;
              uvalid_q <= 1'b1;
              state_q  <= SEND_SIZE;
            end else if (word_count == 32'd0) begin
              state_q  <= DONE;
            end else begin
              mvalid_q <= 1'b1;
              state_q  <= FETCH;
            end
          end
        end
        SEND_SIZE, SEND_WORD: begin
          if (uvalid_q && bus.uart_in_ready) begin
            if (idx_q == 2'd3) begin
              idx_q    <= 2'd0;
              uvalid_q <= 1'b0;
              if (remaining_q != 32'd0) begin
                mvalid_q <= 1'b1;
                state_q  <= FETCH;
              end else begin
                state_q  <= DONE;
              end
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        FETCH: begin
          if (bus.data_mem_out_ready) begin
            buf_q       <= bus.data_mem_out_data;
            mvalid_q    <= 1'b0;
            addr_q      <= addr_q + 32'(ADDR_STEP);
            remaining_q <= remaining_q - 32'd1;
            uvalid_q    <= 1'b1;
            state_q     <= SEND_WORD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_dumper.sv
// Scoreboard bench: tests push expected bytes/addresses, monitors pop and compare.
module tb_memory_dumper;
  logic        clk = 1'b0;
  logic        reset;
  logic        start, start_b;
  logic [31:0] base_addr, word_count;
  logic        busy, completed, busy_b, completed_b;
  logic        uart_toggle;
  int          stall_req;
  int          wcnt;
  int          rcyc;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          byte_cnt = 0;
  int          mem_reads = 0;
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_addr[$];
  logic [3:0]  rdy_pat = 4'b1001;

  memory_dumper_if ifa();
  memory_dumper_if ifb();

  memory_dumper #(.SEND_HEADER(1'b1), .ADDR_STEP(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .completed(completed), .bus(ifa.master));
  memory_dumper #(.SEND_HEADER(1'b0), .ADDR_STEP(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .base_addr(base_addr),
    .word_count(word_count), .busy(busy_b), .completed(completed_b), .bus(ifb.master));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_rd = 32'h1122_3344;
      32'h0000_0104: mem_rd = 32'hAABB_CCDD;
      32'hFFFF_FFFC: mem_rd = 32'h0102_0304;
      32'h0000_0000: mem_rd = 32'h0506_0708;
      default:       mem_rd = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign ifa.data_mem_out_data  = mem_rd(ifa.data_mem_out_addr);
  assign ifa.data_mem_out_ready = ifa.data_mem_out_valid && (wcnt >= stall_req);
  assign ifb.data_mem_out_data  = 32'h0;
  assign ifb.data_mem_out_ready = 1'b0;
  assign ifb.uart_in_ready      = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // memory stall counter
  always @(posedge clk) begin
    if (reset || !ifa.data_mem_out_valid || ifa.data_mem_out_ready) wcnt = 0;
    else wcnt = wcnt + 1;
  end

  // transmitter ready pattern
  always @(posedge clk) begin
    #1;
    if (uart_toggle) begin
      ifa.uart_in_ready = rdy_pat[rcyc % 4];
      rcyc = rcyc + 1;
    end else begin
      ifa.uart_in_ready = 1'b1;
      rcyc = 0;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, ifa.uart_in_valid}, 32'd1);
        chk("stall_data", {24'd0, ifa.uart_in_data}, {24'd0, prev_data});
      end
      prev_stall = ifa.uart_in_valid && !ifa.uart_in_ready;
      prev_data  = ifa.uart_in_data;
      if (ifa.uart_in_valid && ifa.uart_in_ready) begin
        byte_cnt++;
        if (exp_bytes.size() == 0) chk("extra_byte", {24'd0, ifa.uart_in_data}, 32'hFFFF_FFFF);
        else chk("byte", {24'd0, ifa.uart_in_data}, {24'd0, exp_bytes.pop_front()});
      end
      if (ifa.data_mem_out_valid) begin
        chk("uvalid_in_fetch", {31'd0, ifa.uart_in_valid}, 32'd0);
        if (exp_addr.size() == 0) chk("extra_read", ifa.data_mem_out_addr, 32'hFFFF_FFFF);
        else chk("read_addr", ifa.data_mem_out_addr, exp_addr[0]);
        if (ifa.data_mem_out_ready) begin
          mem_reads++;
          if (exp_addr.size() != 0) void'(exp_addr.pop_front());
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(w[i*8 +: 8]);
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [31:0] n);
    base_addr = b; word_count = n; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!completed && n < 300) begin tick; n++; end
    chk({nm, "_completed"}, {31'd0, completed}, 32'd1);
    chk({nm, "_bytes_left"}, exp_bytes.size(), 32'd0);
    chk({nm, "_reads_left"}, exp_addr.size(), 32'd0);
  endtask

  initial begin
    int n, snap;
    reset = 1'b1; start = 1'b0; start_b = 1'b0; base_addr = '0; word_count = '0;
    uart_toggle = 1'b0; stall_req = 0; ifa.uart_in_ready = 1'b1;
    tick; tick;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_completed", {31'd0, completed}, 32'd0);
    chk("rst_mvalid", {31'd0, ifa.data_mem_out_valid}, 32'd0);
    chk("rst_uvalid", {31'd0, ifa.uart_in_valid}, 32'd0);
    chk("rst_addr", ifa.data_mem_out_addr, 32'd0);
    chk("rst_udata", {24'd0, ifa.uart_in_data}, 32'd0);
    reset = 1'b0;
    tick;

    // basic two-word dump
    push_word(32'd8); push_word(32'h1122_3344); push_word(32'hAABB_CCDD);
    exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
    pulse_start(32'h100, 32'd2);
    chk("t1_latency", {31'd0, ifa.uart_in_valid}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_completed_drop", {31'd0, completed}, 32'd0);
    wait_done("t1");

    // transmitter back-pressure
    uart_toggle = 1'b1;
    push_word(32'd8); push_word(32'h1122_3344); push_word(32'hAABB_CCDD);
    exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
    pulse_start(32'h100, 32'd2);
    wait_done("t2");
    uart_toggle = 1'b0;
    tick;

    // memory stall on first fetch
    stall_req = 5;
    snap = mem_reads;
    push_word(32'd8); push_word(32'h1122_3344); push_word(32'hAABB_CCDD);
    exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
    pulse_start(32'h100, 32'd2);
    n = 0;
    while (mem_reads == snap && n < 100) begin tick; n++; end
    chk("t3_first_read_seen", mem_reads - snap, 32'd1);
    stall_req = 0;
    wait_done("t3");

    // zero words with header
    snap = mem_reads;
    push_word(32'd0);
    pulse_start(32'h200, 32'd0);
    wait_done("t4");
    chk("t4_no_reads", mem_reads - snap, 32'd0);

    // zero words without header
    base_addr = 32'h200; word_count = 32'd0; start_b = 1'b1;
    tick;
    start_b = 1'b0;
    chk("t5_completed", {31'd0, completed_b}, 32'd1);
    chk("t5_busy", {31'd0, busy_b}, 32'd0);
    chk("t5_no_mem", {31'd0, ifb.data_mem_out_valid}, 32'd0);
    chk("t5_no_uart", {31'd0, ifb.uart_in_valid}, 32'd0);

    // address wrap
    push_word(32'd8); push_word(32'h0102_0304); push_word(32'h0506_0708);
    exp_addr.push_back(32'hFFFF_FFFC); exp_addr.push_back(32'h0);
    pulse_start(32'hFFFF_FFFC, 32'd2);
    wait_done("t6");

    // reset during third byte of first data word
    push_word(32'd8); push_word(32'h1122_3344); push_word(32'hAABB_CCDD);
    exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
    snap = byte_cnt;
    pulse_start(32'h100, 32'd2);
    n = 0;
    while (byte_cnt - snap < 6 && n < 100) begin tick; n++; end
    chk("t7_reached_byte", byte_cnt - snap, 32'd6);
    reset = 1'b1;
    exp_bytes.delete(); exp_addr.delete();
    tick;
    reset = 1'b0;
    chk("t7_busy", {31'd0, busy}, 32'd0);
    chk("t7_completed", {31'd0, completed}, 32'd0);
    chk("t7_uvalid", {31'd0, ifa.uart_in_valid}, 32'd0);
    chk("t7_mvalid", {31'd0, ifa.data_mem_out_valid}, 32'd0);
    chk("t7_addr", ifa.data_mem_out_addr, 32'd0);
    chk("t7_udata", {24'd0, ifa.uart_in_data}, 32'd0);
    push_word(32'd4); push_word(32'h0506_0708);
    exp_addr.push_back(32'h0);
    pulse_start(32'h0, 32'd1);
    tick; tick;
    pulse_start(32'h500, 32'd9);
    wait_done("t7");
    chk("t7_total_bytes", byte_cnt - snap, 32'd14);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
